// File: rtl/data_mem_sized.sv
// Byte-addressed RV32 data memory, sized B/H/W access with sign/zero extension; DATA_MEM_SPLIT_EN enables two-beat word-crossing accesses.
// Load data one cycle after acceptance (two when split); req_ready drops only during the second beat, and there is no response backpressure.
module data_mem_sized #(
    parameter int    ADDRESS_WIDTH = 32,
    parameter int    DATA_WIDTH    = 32,
    parameter int    MEM_ADDR_BITS = 10,
    parameter string INIT_FILE     = "data.mem"
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wd,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rd,
    output logic                     access_err
);

    localparam int WIB      = MEM_ADDR_BITS - 2;
    localparam int WORDS    = 1 << WIB;
    localparam bit HAS_INIT = (INIT_FILE != "");

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("data_mem_sized: DATA_WIDTH must be 32");
    end

`ifdef DATA_MEM_SPLIT_EN
    typedef enum logic [1:0] {S_IDLE, S_RESP, S_SPLIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RESP} state_t;
`endif

    state_t      state, state_nxt;
    logic [31:0] mem [WORDS];

    logic [WIB-1:0] w0;
    logic [1:0]     off;
    logic [2:0]     f3;
    logic [3:0]     size_mask;
    logic [7:0]     be8;
    logic [63:0]    wd64;
    logic [31:0]    ld_lane;
    logic           crosses, bad_f3, reject, accept, go_split;
    logic           wr_en;
    logic [WIB-1:0] wr_idx;
    logic [3:0]     wr_be;
    logic [31:0]    wr_dat;
    logic           unused_bits;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] fn);
        case (fn)
            3'b000:  extend = {{24{v[7]}}, v[7:0]};
            3'b001:  extend = {{16{v[15]}}, v[15:0]};
            3'b100:  extend = {24'h0, v[7:0]};
            3'b101:  extend = {16'h0, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    assign w0  = req_addr[MEM_ADDR_BITS-1:2];
    assign off = req_addr[1:0];
    assign f3  = req_funct3;

    always_comb begin
        case (f3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Lanes across two consecutive words; the upper nibble marks bytes in the next word.
    assign be8     = {4'b0000, size_mask} << off;
    assign wd64    = {32'h0, req_wd} << {off, 3'b000};
    assign crosses = |be8[7:4];
    assign bad_f3  = req_we ? (f3[2] | (f3[1:0] == 2'b11))
                            : ((f3 == 3'b011) | (f3[2:1] == 2'b11));
    assign ld_lane = mem[w0] >> {off, 3'b000};

`ifdef DATA_MEM_SPLIT_EN
    logic [31:0]    lo_q, hi_wd_q;
    logic [WIB-1:0] w1_q;
    logic [1:0]     off_q;
    logic [2:0]     f3_q;
    logic           st_q;
    logic [3:0]     hi_be_q;
    logic [63:0]    merged;

    assign reject    = bad_f3;
    assign merged    = {mem[w1_q], lo_q} >> {off_q, 3'b000};
    assign req_ready = (state != S_SPLIT);
    assign unused_bits = ^{req_addr[ADDRESS_WIDTH-1:MEM_ADDR_BITS], merged[63:32], HAS_INIT};
`else
    assign reject    = bad_f3 | crosses;
    assign req_ready = 1'b1;
    assign unused_bits = ^{req_addr[ADDRESS_WIDTH-1:MEM_ADDR_BITS], wd64[63:32], HAS_INIT};
`endif

    assign accept    = req_valid & req_ready;
    assign go_split  = accept & ~reject & crosses;
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        if (accept) begin
`ifdef DATA_MEM_SPLIT_EN
            if (go_split) state_nxt = S_SPLIT;
            else
`endif
            if (reject | ~req_we) state_nxt = S_RESP;
        end
`ifdef DATA_MEM_SPLIT_EN
        if (state == S_SPLIT) state_nxt = st_q ? S_IDLE : S_RESP;
`endif
    end

    always_comb begin
        wr_en  = accept & req_we & ~reject;
        wr_idx = w0;
        wr_be  = be8[3:0];
        wr_dat = wd64[31:0];
`ifdef DATA_MEM_SPLIT_EN
        if (state == S_SPLIT && st_q) begin
            wr_en  = 1'b1;
            wr_idx = w1_q;
            wr_be  = hi_be_q;
            wr_dat = hi_wd_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rd     <= '0;
            access_err <= 1'b0;
`ifdef DATA_MEM_SPLIT_EN
            lo_q    <= '0;
            hi_wd_q <= '0;
            w1_q    <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            st_q    <= 1'b0;
            hi_be_q <= '0;
`endif
        end else begin
            rsp_rd     <= '0;
            access_err <= 1'b0;
            if (accept & ~go_split) begin
                if (reject)       access_err <= 1'b1;
                else if (!req_we) rsp_rd     <= extend(ld_lane, f3);
            end
`ifdef DATA_MEM_SPLIT_EN
            if (go_split) begin
                lo_q    <= mem[w0];
                w1_q    <= w0 + WIB'(1);
                off_q   <= off;
                f3_q    <= f3;
                st_q    <= req_we;
                hi_be_q <= be8[7:4];
                hi_wd_q <= wd64[63:32];
            end
            if (state == S_SPLIT && !st_q) rsp_rd <= extend(merged[31:0], f3_q);
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// Bench for data_mem_sized: vector table plus crossing/reset sequences, scoreboard checks response timing and data.
module tb_data_mem_sized;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wd;
    logic        rsp_valid, access_err;
    logic [31:0] rsp_rd;

    always #5 clk = ~clk;

    data_mem_sized #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_ADDR_BITS(10),
        .INIT_FILE("")
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wd(req_wd),
        .rsp_valid(rsp_valid),
        .rsp_rd(rsp_rd),
        .access_err(access_err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rsp;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic rsp, input logic err,
                                input logic [31:0] rd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rsp = rsp; v.err = err; v.rd = rd;
        return v;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("access_err", {31'h0, access_err}, {31'h0, mon_e.err});
            chk("rsp_rd", rsp_rd, mon_e.rd);
        end else begin
            chk("no_rsp", {31'h0, rsp_valid}, 32'h0);
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic rsp, input logic err,
                         input logic [31:0] rd, input int lat);
        exp_t e;
        int   n;
        n = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wd     = wd;
        while (!req_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("req_ready_wait", {31'h0, req_ready}, 32'h1);
        if (rsp) begin
            e.due = cyc + lat;
            e.err = err;
            e.rd  = rd;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk(1, 3'b010, 32'h0000_0000, 32'ha5a5_c3c3, 0, 0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h0000_03fc, 32'h5566_7788, 0, 0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h0000_0010, 32'h8bad_f00d, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0010, 32'h0,         1, 0, 32'h8bad_f00d));
        vecs.push_back(mk(1, 3'b000, 32'h0000_0013, 32'hffff_ff80, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h0000_0013, 32'h0,         1, 0, 32'hffff_ff80));
        vecs.push_back(mk(0, 3'b100, 32'h0000_0013, 32'h0,         1, 0, 32'h0000_0080));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0012, 32'h0,         1, 0, 32'hffff_80ad));
        vecs.push_back(mk(0, 3'b101, 32'h0000_0012, 32'h0,         1, 0, 32'h0000_80ad));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0011, 32'h0,         1, 0, 32'hffff_adf0));
        vecs.push_back(mk(1, 3'b001, 32'h0000_0002, 32'h1234_beef, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0000, 32'h0,         1, 0, 32'hbeef_c3c3));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0001, 32'h0,         1, 0, 32'hffff_efc3));
        vecs.push_back(mk(0, 3'b001, 32'h0000_03fe, 32'h0,         1, 0, 32'h0000_5566));
        vecs.push_back(mk(0, 3'b100, 32'h0000_03fc, 32'h0,         1, 0, 32'h0000_0088));
        vecs.push_back(mk(0, 3'b000, 32'h0000_03fd, 32'h0,         1, 0, 32'h0000_0077));
        vecs.push_back(mk(0, 3'b101, 32'h0000_03fd, 32'h0,         1, 0, 32'h0000_6677));
        vecs.push_back(mk(0, 3'b010, 32'hffff_f010, 32'h0,         1, 0, 32'h80ad_f00d));
        vecs.push_back(mk(0, 3'b011, 32'h0000_0010, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 3'b110, 32'h0000_0000, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(0, 3'b111, 32'h0000_0010, 32'h0,         1, 1, 32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h0000_0010, 32'hffff_ffff, 1, 1, 32'h0));
        vecs.push_back(mk(1, 3'b011, 32'h0000_0010, 32'hffff_ffff, 1, 1, 32'h0));
        vecs.push_back(mk(1, 3'b111, 32'h0000_0010, 32'hffff_ffff, 1, 1, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0010, 32'h0,         1, 0, 32'h80ad_f00d));

        rst_n = 1'b0;
        idle();
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wd     = 32'h0;
        #12;
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rd", rsp_rd, 32'h0);
        chk("reset_access_err", {31'h0, access_err}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;

        foreach (vecs[i])
            issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                  vecs[i].rsp, vecs[i].err, vecs[i].rd, 1);
        idle();
        @(posedge clk); #1;

`ifndef DATA_MEM_SPLIT_EN
        issue(1, 3'b001, 32'h0000_03ff, 32'h0000_beef, 1, 1, 32'h0, 1);
        chk("ready_after_cross", {31'h0, req_ready}, 32'h1);
        issue(0, 3'b100, 32'h0000_03ff, 32'h0, 1, 0, 32'h0000_0055, 1);
        issue(0, 3'b010, 32'h0000_0000, 32'h0, 1, 0, 32'hbeef_c3c3, 1);
        issue(0, 3'b010, 32'h0000_0011, 32'h0, 1, 1, 32'h0, 1);
        issue(0, 3'b001, 32'h0000_0013, 32'h0, 1, 1, 32'h0, 1);
        idle();
`else
        issue(1, 3'b010, 32'h0000_0010, 32'h3322_1100, 0, 0, 32'h0, 1);
        issue(1, 3'b010, 32'h0000_0014, 32'h7766_5544, 0, 0, 32'h0, 1);
        issue(1, 3'b000, 32'h0000_0018, 32'h0000_0088, 0, 0, 32'h0, 1);
        issue(0, 3'b010, 32'h0000_0015, 32'h0, 1, 0, 32'h8877_6655, 2);
        chk("split_ready_low", {31'h0, req_ready}, 32'h0);
        issue(1, 3'b001, 32'h0000_03ff, 32'h0000_beef, 0, 0, 32'h0, 1);
        issue(0, 3'b001, 32'h0000_03ff, 32'h0, 1, 0, 32'hffff_beef, 2);
        issue(0, 3'b100, 32'h0000_0000, 32'h0, 1, 0, 32'h0000_00be, 1);
        issue(0, 3'b100, 32'h0000_03ff, 32'h0, 1, 0, 32'h0000_00ef, 1);
        issue(1, 3'b010, 32'h0000_03fe, 32'h1122_3344, 0, 0, 32'h0, 1);
        idle();
        rst_n = 1'b0;
        #1;
        chk("split_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("split_rst_rsp_rd", rsp_rd, 32'h0);
        chk("split_rst_access_err", {31'h0, access_err}, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("split_rst_ready", {31'h0, req_ready}, 32'h1);
        issue(0, 3'b010, 32'h0000_03fc, 32'h0, 1, 0, 32'h3344_7788, 1);
        issue(0, 3'b101, 32'h0000_0000, 32'h0, 1, 0, 32'h0000_c3be, 1);
        idle();
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
